mac_accumulator: RTL and testbench

MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

---
 rtl/mac_accumulator.sv | 151 +++++++++++++++
 tb/tb_mac_accumulator.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mac_accumulator.sv
// mac_accumulator: accumulates a counted burst of signed 16-bit products from
// an upstream multiplier into a signed ACC_W-bit result, then offers the
// result downstream with a valid/ready handshake.
//
// Build option: define MAC_SAT_EN for saturating additions and a sticky
// saturation flag. Without it, additions wrap and sat is tied low.
module mac_accumulator #(
    parameter int ACC_W = 20,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [15:0]      p_data,
    input  logic             p_valid,
    output logic             p_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sat
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]   len_q, len_d;

    logic [ACC_W-1:0]   prod_ext;
    logic [ACC_W-1:0]   sum_next;
    logic               sum_clip;
    logic [LEN_W-1:0]   cnt_inc;
    logic               accept;

    // Product handshake only completes while accumulating.
    assign accept   = (state_q == ST_ACCUM) && p_valid;
    assign cnt_inc  = cnt_q + {{(LEN_W-1){1'b0}}, 1'b1};
    assign prod_ext = {{(ACC_W-16){p_data[15]}}, p_data};

`ifdef MAC_SAT_EN
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [ACC_W:0] sum_wide;
    logic           sat_q, sat_d;

    // One guard bit exposes signed overflow; clip toward the side it overflowed.
    always_comb begin
        sum_wide = {acc_q[ACC_W-1], acc_q} + {prod_ext[ACC_W-1], prod_ext};
        sum_clip = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
        if (sum_clip) begin
            sum_next = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
        end else begin
            sum_next = sum_wide[ACC_W-1:0];
        end
    end

    // Sticky clip flag: cleared on a new start, set by any clipped addition.
    always_comb begin
        sat_d = sat_q;
        if (state_q == ST_IDLE && start) begin
            sat_d = 1'b0;
        end else if (accept && sum_clip) begin
            sat_d = 1'b1;
        end
    end

    // Saturation flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end

    assign sat = sat_q;
`else
    // Plain modulo-2^ACC_W addition; no overflow detection needed.
    always_comb begin
        sum_next = acc_q + prod_ext;
        sum_clip = 1'b0;
    end

    assign sat = 1'b0;
`endif

    // Next-state, accumulator and counter updates.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    len_d   = len;
                    state_d = (len != '0) ? ST_ACCUM : ST_DONE;
                end
            end
            ST_ACCUM: begin
                // Idle cycles (p_valid low) simply wait; there is no timeout.
                if (accept) begin
                    acc_d = sum_next;
                    cnt_d = cnt_inc;
                    if (cnt_inc == len_q) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                // start is deliberately not looked at here, forcing a bubble.
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
        end
    end

    // Result comes straight from the accumulator register.
    assign out_data  = acc_q;
    assign out_valid = (state_q == ST_DONE);
    assign p_ready   = (state_q == ST_ACCUM);

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed testbench for mac_accumulator (ACC_W=20, LEN_W=8).
module tb_mac_accumulator;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic [15:0] p_data;
    logic        p_valid;
    logic        p_ready;
    logic [19:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        sat;

    int total = 0;
    int bad   = 0;

    mac_accumulator #(.ACC_W(20), .LEN_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .p_data    (p_data),
        .p_valid   (p_valid),
        .p_ready   (p_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sat       (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]         len;
        logic [3:0][15:0]   p;
        logic [7:0]         gap;
        logic signed [19:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    function automatic int od();
        return int'($signed(out_data));
    endfunction

    // Present start for one edge; returns at the following negedge.
    task automatic do_start(input logic [7:0] l);
        @(negedge clk);
        start = 1'b1;
        len   = l;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offer one product for one edge, then idle for gap cycles.
    task automatic feed(input logic [15:0] p, input int gap);
        p_valid = 1'b1;
        p_data  = p;
        @(negedge clk);
        p_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    // Expect a result to be present now, check it, then complete the handshake.
    task automatic finish(input string name, input int exp_d, input int exp_s);
        chk({name, " out_valid"}, int'(out_valid), 1);
        chk({name, " out_data"}, od(), exp_d);
        chk({name, " sat"}, int'(sat), exp_s);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({name, " idle after handshake"}, int'(out_valid), 0);
    endtask

    initial begin
        int  hold_val;
        rst       = 1'b1;
        start     = 1'b0;
        len       = '0;
        p_data    = '0;
        p_valid   = 1'b0;
        out_ready = 1'b0;

        vecs[0] = '0; vecs[0].len = 8'd3; vecs[0].exp_data = 20'sd250;
        vecs[0].p[0] = 16'sd100; vecs[0].p[1] = 16'sd200; vecs[0].p[2] = -16'sd50;
        vecs[1] = '0; vecs[1].len = 8'd0; vecs[1].exp_data = 20'sd0;
        vecs[2] = '0; vecs[2].len = 8'd2; vecs[2].gap = 8'd3; vecs[2].exp_data = -20'sd2;
        vecs[2].p[0] = 16'sd7; vecs[2].p[1] = -16'sd9;
        vecs[3] = '0; vecs[3].len = 8'd4; vecs[3].exp_data = -20'sd131072;
        vecs[3].p[0] = 16'h8000; vecs[3].p[1] = 16'h8000;
        vecs[3].p[2] = 16'h8000; vecs[3].p[3] = 16'h8000;
        vecs[4] = '0; vecs[4].len = 8'd1; vecs[4].gap = 8'd1; vecs[4].exp_data = 20'sd32767;
        vecs[4].p[0] = 16'sd32767;
        vecs[5] = '0; vecs[5].len = 8'd3; vecs[5].gap = 8'd2; vecs[5].exp_data = -20'sd1;
        vecs[5].p[0] = -16'sd1; vecs[5].p[1] = 16'sd1; vecs[5].p[2] = -16'sd1;

        // Reset state
        #1;
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset p_ready", int'(p_ready), 0);
        chk("reset out_data", od(), 0);
        chk("reset sat", int'(sat), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Products offered in IDLE must be dropped
        p_valid = 1'b1;
        p_data  = 16'sd500;
        repeat (2) @(negedge clk);
        p_valid = 1'b0;
        chk("idle drop p_ready", int'(p_ready), 0);

        // Table-driven jobs
        for (int i = 0; i < 6; i++) begin
            do_start(vecs[i].len);
            if (vecs[i].len != 0) begin
                chk($sformatf("vec%0d p_ready", i), int'(p_ready), 1);
            end
            for (int k = 0; k < int'(vecs[i].len); k++) begin
                feed(vecs[i].p[k], (k == int'(vecs[i].len) - 1) ? 0 : int'(vecs[i].gap));
            end
            finish($sformatf("vec%0d", i), int'(vecs[i].exp_data), 0);
        end

        // start during ACCUM is ignored
        do_start(8'd2);
        start = 1'b1;
        len   = 8'd0;
        feed(16'sd3, 0);
        start = 1'b0;
        feed(16'sd4, 0);
        finish("start in accum", 7, 0);

        // Long burst: saturates or wraps depending on build
        do_start(8'd40);
        for (int k = 0; k < 40; k++) feed(16'sd16384, 0);
`ifdef MAC_SAT_EN
        finish("len40", 524287, 1);
`else
        finish("len40", -393216, 0);
`endif

        // Backpressure in DONE with noise on p_valid and start
        do_start(8'd2);
        feed(16'sd5, 0);
        feed(16'sd6, 0);
        p_valid = 1'b1;
        p_data  = 16'sd1234;
        start   = 1'b1;
        len     = 8'd1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("bp%0d out_valid", c), int'(out_valid), 1);
            chk($sformatf("bp%0d out_data", c), od(), 11);
            chk($sformatf("bp%0d p_ready", c), int'(p_ready), 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp handshake out_valid", int'(out_valid), 0);
        chk("bp handshake p_ready", int'(p_ready), 0);
        start   = 1'b0;
        p_valid = 1'b0;

        // Reset mid-accumulation
        do_start(8'd4);
        feed(16'sd1000, 0);
        feed(16'sd2000, 0);
        #2 rst = 1'b1;
        #1;
        chk("midrst p_ready", int'(p_ready), 0);
        chk("midrst out_data", od(), 0);
        chk("midrst out_valid", int'(out_valid), 0);
        chk("midrst sat", int'(sat), 0);
        @(negedge clk);
        rst = 1'b0;
        hold_val = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (out_valid || p_ready) hold_val = 1;
        end
        chk("no result after reset", hold_val, 0);
        rst = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b1;
        len   = 8'd1;
        @(negedge clk);
        start = 1'b0;
        chk("first start after reset", int'(p_ready), 1);
        feed(16'hFF80, 0);
        finish("after reset", -128, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
